// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin drain of four class FIFOs into one output FIFO.
// Optional strict priority for class 0 with `define QOS_STRICT_PRIO_EN.
module qos_wrr_scheduler #(
    parameter int DW = 12,
    parameter int WW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [3:0]    empty,
    input  logic          dst_afull,
    input  logic [WW-1:0] weight0,
    input  logic [WW-1:0] weight1,
    input  logic [WW-1:0] weight2,
    input  logic [WW-1:0] weight3,
    input  logic [DW-1:0] fifo_out0,
    input  logic [DW-1:0] fifo_out1,
    input  logic [DW-1:0] fifo_out2,
    input  logic [DW-1:0] fifo_out3,
    output logic [3:0]    pop,
    output logic          push,
    output logic [DW-1:0] data_out,
    output logic [1:0]    grant_idx,
    output logic [7:0]    round_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        RELOAD
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [WW-1:0] credit [4];
    logic [WW-1:0] wt     [4];
    logic [3:0]    elig;
    logic [3:0]    want;
    logic          found;
    logic [1:0]    sel;
    logic          fire;
    logic          wrr_hit;
    logic          need_reload;

    assign wt[0] = weight0;
    assign wt[1] = weight1;
    assign wt[2] = weight2;
    assign wt[3] = weight3;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            elig[i] = !empty[i] && (credit[i] != '0);
            want[i] = !empty[i] && (wt[i] != '0);
        end
`ifdef QOS_STRICT_PRIO_EN
        elig[0] = !empty[0];
        want[0] = 1'b0;
`endif
    end

    // Rotating scan starting at ptr; first eligible class wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && elig[ptr + 2'(k)]) begin
                found = 1'b1;
                sel   = ptr + 2'(k);
            end
        end
`ifdef QOS_STRICT_PRIO_EN
        if (elig[0]) begin
            found = 1'b1;
            sel   = 2'd0;
        end
`endif
    end

    assign need_reload = |want;

    assign fire = !reset && (state == ARB) && enable
                  && !dst_afull && found;

`ifdef QOS_STRICT_PRIO_EN
    assign wrr_hit = fire && (sel != 2'd0);
`else
    assign wrr_hit = fire;
`endif

    always_comb begin
        pop = 4'b0000;
        if (fire) begin
            pop[sel] = 1'b1;
        end
    end

    // Class FIFOs present read data the cycle after pop, so the
    // registered grant selects the word that is live during push.
    always_comb begin
        data_out = '0;
        if (push) begin
            unique case (grant_idx)
                2'd0: data_out = fifo_out0;
                2'd1: data_out = fifo_out1;
                2'd2: data_out = fifo_out2;
                2'd3: data_out = fifo_out3;
                default: data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            push      <= 1'b0;
            grant_idx <= 2'd0;
            round_cnt <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                credit[i] <= '0;
            end
        end else begin
            push <= fire;
            if (fire) begin
                grant_idx <= sel;
            end
            if (wrr_hit) begin
                assert (credit[sel] != '0);
                if (credit[sel] != '0) begin
                    credit[sel] <= credit[sel] - WW'(1);
                end
                // Stay on the class while it still has credit left.
                if (credit[sel] > WW'(1)) begin
                    ptr <= sel;
                end else begin
                    ptr <= sel + 2'd1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (!dst_afull && !found
                                 && need_reload) begin
                        state <= RELOAD;
                    end
                end
                RELOAD: begin
                    for (int i = 0; i < 4; i++) begin
                        credit[i] <= wt[i];
                    end
                    round_cnt <= round_cnt + 8'd1;
                    state     <= ARB;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
